sysid_boot_checker: RTL and testbench
=====================================

Name: sysid_boot_checker

Overview:
- Avalon-MM read master that sequences the system-ID slave after reset or on request.
- Reads the ID word (address 0) and the timestamp word (address 1), then compares both against expected values.
- Retries on mismatch or timeout; latches a pass/fail verdict with a cause code.
- Sits between the sysid control slave and the board status logic (LEDs/hex and a CPU-visible status register) so a mismatched bitstream/software pairing is flagged without CPU involvement.

Parameters:
- READ_LATENCY, 0: cycles from read acceptance (waitrequest low) to valid readdata; 0 = sample readdata in the acceptance cycle.
- TIMEOUT_CYCLES, 255: maximum cycles one read may spend in RD_x plus WAIT_x before the attempt fails with timeout; range 1..65535.
- MAX_RETRIES, 2: extra attempts after the first failed attempt; range 0..15.
- AUTO_START, 1: 1 = begin a check in the first cycle after reset deasserts; 0 = wait for start.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to run a check; honoured only in IDLE or DONE.
- expected_id  in  32  expected ID word.
- expected_ts  in  32  expected timestamp word.
- avm_address  out  1  0 = ID, 1 = timestamp.
- avm_read  out  1  read strobe.
- avm_waitrequest  in  1  slave stall; tie 0 for the sysid slave.
- avm_readdata  in  32  read data.
- busy  out  1  high in any state other than IDLE/DONE.
- done  out  1  verdict valid; held until next start or reset.
- pass  out  1  both words matched on the final attempt; valid when done=1.
- fail_code  out  2  00 none, 01 ID mismatch, 10 timestamp mismatch (ID ok), 11 timeout; valid when done=1.
- attempts  out  4  attempts made in the current/last check (1..MAX_RETRIES+1).
- id_value  out  32  last captured ID word.
- ts_value  out  32  last captured timestamp word.

Behaviour:
- Reset (synchronous):
  - Outputs: avm_read=0, avm_address=0, busy=0, done=0, pass=0, fail_code=00, attempts=0, id_value=0, ts_value=0.
  - State after reset: RD_ID if AUTO_START=1, else IDLE. Reset while busy abandons the read with no further strobes.
- States: IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, CHECK, DONE.
- IDLE/DONE + start:
  - Go to RD_ID next cycle.
  - Clear done/pass/fail_code; set attempts=1.
  - start in any other state is ignored.
- RD_ID: avm_read=1, avm_address=0, held stable while avm_waitrequest=1.
  - Acceptance cycle: waitrequest=0.
  - READ_LATENCY=0: capture readdata into id_value in the acceptance cycle, go to RD_TS.
  - READ_LATENCY>0: go to WAIT_ID (avm_read=0); capture exactly READ_LATENCY cycles after acceptance, then go to RD_TS.
- RD_TS/WAIT_TS: identical to RD_ID/WAIT_ID with avm_address=1; capture into ts_value, then go to CHECK.
- Timeout counter:
  - Cleared on entry to each RD_x; counts every cycle in RD_x/WAIT_x.
  - Reaching TIMEOUT_CYCLES ends the attempt with cause 11; next state follows the CHECK retry rule.
  - Timeout has priority over a same-cycle acceptance.
- CHECK: one cycle. Cause priority: timeout (11) > ID mismatch (01) > timestamp mismatch (10).
  - No failure → DONE, pass=1, fail_code=00.
  - Failure and attempts ≤ MAX_RETRIES → attempts+1, back to RD_ID.
  - Otherwise → DONE, pass=0, fail_code=cause.
- Latency: no stall, READ_LATENCY=0, start at cycle n gives RD_ID at n+1, RD_TS at n+2, CHECK at n+3, done=1 at n+4. Each latency cycle adds 1 per word.
- done, pass and fail_code are registered; they change only on DONE entry or on a start from DONE.
- expected_id and expected_ts are sampled combinationally in CHECK; they must be stable during busy.

Test Plan:
- AUTO_START=1, slave returns 0 @addr0 and 0x5A9F6B73 @addr1, expected_id=0, expected_ts=0x5A9F6B73 → done=1 at 4th cycle after reset release, pass=1, fail_code=00, attempts=1, ts_value=0x5A9F6B73.
- Same slave, expected_ts=0x5A9F6B74, MAX_RETRIES=2 → three address-0/1 read pairs, then done=1, pass=0, fail_code=10, attempts=3.
- waitrequest held 1 forever, TIMEOUT_CYCLES=8, MAX_RETRIES=0 → avm_read=1 for exactly 8 cycles, done=1, fail_code=11, attempts=1.
- waitrequest high 3 cycles per read, READ_LATENCY=2, matching data → avm_address and avm_read stable during stall, captures correct, pass=1 at cycle n+14.
- First attempt ID word=0x1, second attempt ID=0 → pass=1, attempts=2; start pulses while busy ignored; start from DONE reruns the check and clears done for one cycle.
- reset asserted in WAIT_TS → next cycle all outputs at reset values; with AUTO_START=0 nothing happens until start.

Source files
------------

// File: rtl/sysid_boot_checker.sv
// -----------------------------------------------------------------------------
// sysid_boot_checker
//
// Avalon-MM read master that checks the system-ID slave after reset or on
// request. It reads the ID word (address 0) and the timestamp word
// (address 1), compares both with the expected values and retries on a
// mismatch or timeout. It then latches a pass/fail verdict with a cause code
// for the board status logic, so a mismatched bitstream/software pairing is
// flagged without CPU involvement.
//
// Ports
//   clock            system clock, rising edge
//   reset            synchronous, active-high reset
//   start            one-cycle check request (honoured in IDLE/DONE only)
//   expected_id      expected ID word (stable while busy)
//   expected_ts      expected timestamp word (stable while busy)
//   avm_address      0 = ID word, 1 = timestamp word
//   avm_read         read strobe
//   avm_waitrequest  slave stall
//   avm_readdata     read data
//   busy             check in progress
//   done             verdict valid, held until next start or reset
//   pass             both words matched on the final attempt
//   fail_code        00 none, 01 ID, 10 timestamp, 11 timeout
//   attempts         attempts made in the current/last check
//   id_value         last captured ID word
//   ts_value         last captured timestamp word
// -----------------------------------------------------------------------------
module sysid_boot_checker #(
   parameter int READ_LATENCY   = 0,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int MAX_RETRIES    = 2,
   parameter bit AUTO_START     = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] expected_id,
   input  logic [31:0] expected_ts,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [1:0]  fail_code,
   output logic [3:0]  attempts,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_ID   = 3'd1,
      S_WAIT_ID = 3'd2,
      S_RD_TS   = 3'd3,
      S_WAIT_TS = 3'd4,
      S_CHECK   = 3'd5,
      S_DONE    = 3'd6
   } state_t;

   localparam state_t      RESET_STATE = AUTO_START ? S_RD_ID : S_IDLE;
   localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [15:0] LAT_LAST    = 16'(READ_LATENCY);
   localparam logic [3:0]  RETRY_MAX   = 4'(MAX_RETRIES);

   state_t      state_r;
   state_t      state_nxt;
   logic [15:0] tmo_cnt_r;       // cycles already spent in the current RD_x/WAIT_x
   logic [15:0] lat_cnt_r;       // cycles since the read was accepted
   logic [3:0]  retry_r;         // attempts - 1
   logic        timeout_seen_r;  // current attempt ended by timeout
   logic [31:0] id_value_r;
   logic [31:0] ts_value_r;
   logic        done_r;
   logic        pass_r;
   logic [1:0]  fail_code_r;

   logic        in_read_s;
   logic        in_wait_s;
   logic        timeout_s;
   logic        accept_s;
   logic        capture_s;
   logic        capture_id_s;
   logic        capture_ts_s;
   logic        begin_s;
   logic        retry_s;
   logic        enter_rd_s;
   logic        enter_rd_id_s;
   logic        to_done_s;
   logic [1:0]  cause_s;

   assign in_read_s = (state_r == S_RD_ID) || (state_r == S_RD_TS);
   assign in_wait_s = (state_r == S_WAIT_ID) || (state_r == S_WAIT_TS);

   // The current cycle is the TIMEOUT_CYCLES-th one of this read.
   assign timeout_s = (in_read_s || in_wait_s) && (tmo_cnt_r == TMO_LAST);
   assign accept_s  = in_read_s && !avm_waitrequest;

   // With zero latency the data is taken in the acceptance cycle, otherwise
   // exactly READ_LATENCY cycles later. A same-cycle timeout wins.
   assign capture_s = !timeout_s &&
                      ((READ_LATENCY == 0) ? accept_s
                                           : (in_wait_s && (lat_cnt_r == LAT_LAST)));
   assign capture_id_s = capture_s && ((state_r == S_RD_ID) || (state_r == S_WAIT_ID));
   assign capture_ts_s = capture_s && ((state_r == S_RD_TS) || (state_r == S_WAIT_TS));

   assign enter_rd_s    = ((state_nxt == S_RD_ID) || (state_nxt == S_RD_TS)) &&
                          (state_nxt != state_r);
   assign enter_rd_id_s = (state_nxt == S_RD_ID) && (state_r != S_RD_ID);
   assign to_done_s     = (state_r == S_CHECK) && (state_nxt == S_DONE);

   // Failure cause of the attempt just finished, highest priority first.
   always_comb begin
      cause_s = 2'b00;
      if (timeout_seen_r) begin
         cause_s = 2'b11;
      end else if (id_value_r != expected_id) begin
         cause_s = 2'b01;
      end else if (ts_value_r != expected_ts) begin
         cause_s = 2'b10;
      end else begin
         cause_s = 2'b00;
      end
   end

   // Next-state decode of the read sequencer.
   always_comb begin
      state_nxt = state_r;
      begin_s   = 1'b0;
      retry_s   = 1'b0;
      case (state_r)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_nxt = S_RD_ID;
               begin_s   = 1'b1;
            end else begin
               state_nxt = state_r;
            end
         end
         S_RD_ID: begin
            if (timeout_s) begin
               state_nxt = S_CHECK;
            end else if (accept_s) begin
               state_nxt = (READ_LATENCY == 0) ? S_RD_TS : S_WAIT_ID;
            end else begin
               state_nxt = state_r;
            end
         end
         S_WAIT_ID: begin
            if (timeout_s) begin
               state_nxt = S_CHECK;
            end else if (capture_s) begin
               state_nxt = S_RD_TS;
            end else begin
               state_nxt = state_r;
            end
         end
         S_RD_TS: begin
            if (timeout_s) begin
               state_nxt = S_CHECK;
            end else if (accept_s) begin
               state_nxt = (READ_LATENCY == 0) ? S_CHECK : S_WAIT_TS;
            end else begin
               state_nxt = state_r;
            end
         end
         S_WAIT_TS: begin
            if (timeout_s || capture_s) begin
               state_nxt = S_CHECK;
            end else begin
               state_nxt = state_r;
            end
         end
         S_CHECK: begin
            if (cause_s == 2'b00) begin
               state_nxt = S_DONE;
            end else if (retry_r < RETRY_MAX) begin
               state_nxt = S_RD_ID;
               retry_s   = 1'b1;
            end else begin
               state_nxt = S_DONE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State register, per-read timeout/latency counters and attempt count.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r        <= RESET_STATE;
         tmo_cnt_r      <= 16'd0;
         lat_cnt_r      <= 16'd0;
         retry_r        <= 4'd0;
         timeout_seen_r <= 1'b0;
      end else begin
         state_r <= state_nxt;

         if (enter_rd_s) begin
            tmo_cnt_r <= 16'd0;
         end else if (in_read_s || in_wait_s) begin
            tmo_cnt_r <= tmo_cnt_r + 16'd1;
         end else begin
            tmo_cnt_r <= tmo_cnt_r;
         end

         // Acceptance cycle counts as 0, so the next cycle is 1.
         if (accept_s) begin
            lat_cnt_r <= 16'd1;
         end else if (in_wait_s) begin
            lat_cnt_r <= lat_cnt_r + 16'd1;
         end else begin
            lat_cnt_r <= lat_cnt_r;
         end

         if (begin_s) begin
            retry_r <= 4'd0;
         end else if (retry_s) begin
            retry_r <= retry_r + 4'd1;
         end else begin
            retry_r <= retry_r;
         end

         if (enter_rd_id_s) begin
            timeout_seen_r <= 1'b0;
         end else if (timeout_s) begin
            timeout_seen_r <= 1'b1;
         end else begin
            timeout_seen_r <= timeout_seen_r;
         end
      end
   end

   // Captured words and the latched verdict.
   always_ff @(posedge clock) begin
      if (reset) begin
         id_value_r  <= 32'd0;
         ts_value_r  <= 32'd0;
         done_r      <= 1'b0;
         pass_r      <= 1'b0;
         fail_code_r <= 2'b00;
      end else begin
         if (capture_id_s) begin
            id_value_r <= avm_readdata;
         end else begin
            id_value_r <= id_value_r;
         end

         if (capture_ts_s) begin
            ts_value_r <= avm_readdata;
         end else begin
            ts_value_r <= ts_value_r;
         end

         if (begin_s) begin
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            fail_code_r <= 2'b00;
         end else if (to_done_s) begin
            done_r      <= 1'b1;
            pass_r      <= (cause_s == 2'b00);
            fail_code_r <= cause_s;
         end else begin
            done_r      <= done_r;
            pass_r      <= pass_r;
            fail_code_r <= fail_code_r;
         end
      end
   end

   // The bus strobe, busy and attempts decode straight from the state
   // register. With AUTO_START the register already holds RD_ID while reset
   // is asserted, so these are masked by reset: no strobe is issued during
   // reset, yet the read starts in the very first cycle after release.
   // With MAX_RETRIES=15 the 16th attempt wraps to 0 in the 4-bit field.
   assign avm_read    = !reset && in_read_s;
   assign avm_address = !reset && ((state_r == S_RD_TS) || (state_r == S_WAIT_TS));
   assign busy        = !reset && (state_r != S_IDLE) && (state_r != S_DONE);
   assign attempts    = (reset || (state_r == S_IDLE)) ? 4'd0 : (retry_r + 4'd1);

   assign done      = done_r;
   assign pass      = pass_r;
   assign fail_code = fail_code_r;
   assign id_value  = id_value_r;
   assign ts_value  = ts_value_r;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Bench for sysid_boot_checker: three instances cover auto-start/retries (A),
// timeout and no-retry (B), and stalls plus read latency plus mid-read reset (C).
module tb_sysid_boot_checker;

   localparam logic [31:0] TS_A = 32'h5A9F_6B73;
   localparam logic [31:0] ID_B = 32'h0000_0007;
   localparam logic [31:0] TS_B = 32'hCAFE_0001;
   localparam logic [31:0] ID_C = 32'h1234_ABCD;
   localparam logic [31:0] TS_C = 32'h5A9F_6B73;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string      tag;
      logic       pass;
      logic [1:0] code;
      logic [3:0] att;
   } exp_t;
   exp_t sb[$];

   // ---------------- instance A: defaults, auto start ----------------
   logic        rst_a = 1'b1, start_a = 1'b0, addr_a, rd_a, busy_a, done_a, pass_a;
   logic [31:0] exp_id_a = 32'h0, exp_ts_a = TS_A, rdata_a, idv_a, tsv_a;
   logic [1:0]  code_a;
   logic [3:0]  att_a;
   logic        wait_a = 1'b0;
   logic        bad_first_a = 1'b0;
   int          acc_id_a = 0, acc_ts_a = 0, id_base_a = 0;

   assign rdata_a = addr_a ? TS_A :
                    ((bad_first_a && (acc_id_a == id_base_a)) ? 32'h0000_0001 : 32'h0000_0000);

   always @(posedge clk) begin
      if (rd_a && !wait_a) begin
         if (addr_a) acc_ts_a <= acc_ts_a + 1;
         else        acc_id_a <= acc_id_a + 1;
      end
   end

   sysid_boot_checker #(.READ_LATENCY(0), .TIMEOUT_CYCLES(255), .MAX_RETRIES(2), .AUTO_START(1'b1)) u_a (
      .clock(clk), .reset(rst_a), .start(start_a), .expected_id(exp_id_a), .expected_ts(exp_ts_a),
      .avm_address(addr_a), .avm_read(rd_a), .avm_waitrequest(wait_a), .avm_readdata(rdata_a),
      .busy(busy_a), .done(done_a), .pass(pass_a), .fail_code(code_a), .attempts(att_a),
      .id_value(idv_a), .ts_value(tsv_a));

   // ---------------- instance B: timeout 8, no retries ----------------
   logic        rst_b = 1'b1, start_b = 1'b0, addr_b, rd_b, busy_b, done_b, pass_b;
   logic [31:0] exp_id_b = 32'h0, exp_ts_b = TS_B, rdata_b, idv_b, tsv_b;
   logic [1:0]  code_b;
   logic [3:0]  att_b;
   logic        wait_b = 1'b0;

   assign rdata_b = addr_b ? TS_B : ID_B;

   sysid_boot_checker #(.READ_LATENCY(0), .TIMEOUT_CYCLES(8), .MAX_RETRIES(0), .AUTO_START(1'b0)) u_b (
      .clock(clk), .reset(rst_b), .start(start_b), .expected_id(exp_id_b), .expected_ts(exp_ts_b),
      .avm_address(addr_b), .avm_read(rd_b), .avm_waitrequest(wait_b), .avm_readdata(rdata_b),
      .busy(busy_b), .done(done_b), .pass(pass_b), .fail_code(code_b), .attempts(att_b),
      .id_value(idv_b), .ts_value(tsv_b));

   // ---------------- instance C: 3-cycle stall, latency 2 ----------------
   logic        rst_c = 1'b1, start_c = 1'b0, addr_c, rd_c, busy_c, done_c, pass_c, wait_c;
   logic [31:0] exp_id_c = ID_C, exp_ts_c = TS_C, rdata_c, idv_c, tsv_c;
   logic [1:0]  code_c;
   logic [3:0]  att_c;
   logic [2:0]  stall_c = 3'd0;
   logic [1:0]  pv_c = 2'b00, pa_c = 2'b00;
   logic        hold_pend_c = 1'b0, hold_addr_c = 1'b0, ts_acc_c = 1'b0;

   // Slave model: stall each read 3 cycles, return data 2 cycles after acceptance.
   assign wait_c  = rd_c && (stall_c < 3'd3);
   assign rdata_c = pv_c[1] ? (pa_c[1] ? TS_C : ID_C) : 32'hDEAD_BEEF;

   always @(posedge clk) begin
      if (rd_c) stall_c <= (stall_c < 3'd3) ? stall_c + 3'd1 : 3'd0;
      else      stall_c <= 3'd0;
      pv_c        <= {pv_c[0], rd_c && !wait_c};
      pa_c        <= {pa_c[0], addr_c};
      hold_pend_c <= rd_c && wait_c;
      hold_addr_c <= addr_c;
      ts_acc_c    <= rd_c && !wait_c && addr_c;
   end

   // Address and strobe must not move while the slave stalls.
   always @(negedge clk) begin
      if (hold_pend_c) begin
         chk("C_stall_hold", {30'd0, rd_c, addr_c}, {30'd0, 1'b1, hold_addr_c});
      end
   end

   sysid_boot_checker #(.READ_LATENCY(2), .TIMEOUT_CYCLES(255), .MAX_RETRIES(2), .AUTO_START(1'b0)) u_c (
      .clock(clk), .reset(rst_c), .start(start_c), .expected_id(exp_id_c), .expected_ts(exp_ts_c),
      .avm_address(addr_c), .avm_read(rd_c), .avm_waitrequest(wait_c), .avm_readdata(rdata_c),
      .busy(busy_c), .done(done_c), .pass(pass_c), .fail_code(code_c), .attempts(att_c),
      .id_value(idv_c), .ts_value(tsv_c));

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] verdict_of(input int k);
      case (k)
         0:       return {done_a, pass_a, code_a, att_a};
         1:       return {done_b, pass_b, code_b, att_b};
         default: return {done_c, pass_c, code_c, att_c};
      endcase
   endfunction

   task automatic set_start(input int k, input logic v);
      case (k)
         0:       start_a = v;
         1:       start_b = v;
         default: start_c = v;
      endcase
   endtask

   task automatic expect_verdict(input string tag, input logic p, input logic [1:0] c, input logic [3:0] a);
      exp_t e;
      e.tag = tag; e.pass = p; e.code = c; e.att = a;
      sb.push_back(e);
   endtask

   // Called at a negedge; returns at the negedge after the start edge.
   task automatic pulse_start(input int k);
      set_start(k, 1'b1);
      @(posedge clk);
      @(negedge clk);
      set_start(k, 1'b0);
   endtask

   // Waits (bounded) for done, then pops the oldest expectation and compares.
   task automatic await_verdict(input int k, input int bound, output int cyc);
      exp_t       e;
      logic [7:0] v;
      cyc = 0;
      v   = verdict_of(k);
      while (!v[7] && cyc < bound) begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
         v = verdict_of(k);
      end
      e = sb.pop_front();
      chk({e.tag, "_done"},     32'(v[7]),   32'd1);
      chk({e.tag, "_pass"},     32'(v[6]),   32'(e.pass));
      chk({e.tag, "_code"},     32'(v[5:4]), 32'(e.code));
      chk({e.tag, "_attempts"}, 32'(v[3:0]), 32'(e.att));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int cyc;
      int cnt;
      int base_id;
      int base_ts;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("A_rst_read",   32'(rd_a),   32'd0);
      chk("A_rst_busy",   32'(busy_a), 32'd0);
      chk("A_rst_verdict", 32'(verdict_of(0)), 32'd0);
      chk("A_rst_id",     idv_a,       32'd0);
      chk("A_rst_ts",     tsv_a,       32'd0);

      // A1: auto start, matching words, done in the 4th cycle after release.
      expect_verdict("A1", 1'b1, 2'b00, 4'd1);
      rst_a = 1'b0;
      @(posedge clk); @(posedge clk); @(negedge clk);
      chk("A1_done_early", 32'(done_a), 32'd0);
      @(posedge clk); @(negedge clk);
      chk("A1_done_4th", 32'(done_a), 32'd1);
      await_verdict(0, 0, cyc);
      chk("A1_ts_value", tsv_a, TS_A);

      // A2: timestamp mismatch on every attempt -> three read pairs.
      exp_ts_a = 32'h5A9F_6B74;
      base_id  = acc_id_a;
      base_ts  = acc_ts_a;
      expect_verdict("A2", 1'b0, 2'b10, 4'd3);
      pulse_start(0);
      chk("A2_start_clears_done", 32'(done_a), 32'd0);
      await_verdict(0, 100, cyc);
      chk("A2_id_reads", 32'(acc_id_a - base_id), 32'd3);
      chk("A2_ts_reads", 32'(acc_ts_a - base_ts), 32'd3);

      // A3: first ID read wrong, second good; starts while busy are ignored.
      exp_ts_a    = TS_A;
      bad_first_a = 1'b1;
      id_base_a   = acc_id_a;
      base_id     = acc_id_a;
      expect_verdict("A3", 1'b1, 2'b00, 4'd2);
      pulse_start(0);
      @(negedge clk); start_a = 1'b1;
      chk("A3_busy", 32'(busy_a), 32'd1);
      @(negedge clk); start_a = 1'b0;
      @(negedge clk);
      @(negedge clk); start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      await_verdict(0, 100, cyc);
      chk("A3_id_reads", 32'(acc_id_a - base_id), 32'd2);
      chk("A3_id_value", idv_a, 32'd0);
      bad_first_a = 1'b0;

      // B: no auto start, then ID mismatch, then timeout.
      rst_b = 1'b0;
      repeat (5) @(negedge clk);
      chk("B_idle", {29'd0, busy_b, rd_b, |att_b}, 32'd0);
      expect_verdict("B1", 1'b0, 2'b01, 4'd1);
      pulse_start(1);
      await_verdict(1, 100, cyc);
      chk("B1_id_value", idv_b, ID_B);
      chk("B1_ts_value", tsv_b, TS_B);

      wait_b = 1'b1;
      expect_verdict("B2", 1'b0, 2'b11, 4'd1);
      pulse_start(1);
      cnt = 0;
      for (int i = 0; i < 50 && !done_b; i++) begin
         if (rd_b) cnt++;
         @(negedge clk);
      end
      chk("B2_read_cycles", 32'(cnt), 32'd8);
      await_verdict(1, 10, cyc);

      // C: stalls plus latency, done at n+14.
      rst_c = 1'b0;
      @(negedge clk);
      expect_verdict("C1", 1'b1, 2'b00, 4'd1);
      pulse_start(2);
      await_verdict(2, 100, cyc);
      chk("C1_latency", 32'(cyc), 32'd13);
      chk("C1_id_value", idv_c, ID_C);
      chk("C1_ts_value", tsv_c, TS_C);

      // C2: reset while waiting for the timestamp data.
      pulse_start(2);
      for (int i = 0; i < 100 && !ts_acc_c; i++) @(negedge clk);
      chk("C2_reached_wait_ts", 32'(ts_acc_c), 32'd1);
      rst_c = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("C2_rst_ctrl", {28'd0, rd_c, addr_c, busy_c, done_c}, 32'd0);
      chk("C2_rst_verdict", 32'(verdict_of(2)), 32'd0);
      chk("C2_rst_words", idv_c | tsv_c, 32'd0);
      rst_c = 1'b0;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rd_c || busy_c) cnt++;
      end
      chk("C2_idle_after_rst", 32'(cnt), 32'd0);
      expect_verdict("C3", 1'b1, 2'b00, 4'd1);
      pulse_start(2);
      await_verdict(2, 100, cyc);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
